// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller slice.
//   - sw_state_t   : controller state encoding (run, paused, adjust)
//   - DIGIT_W      : width of one BCD digit
//   - DEF_*_WRAP   : default last value before a field rolls over to 00
package stopwatch_pkg;

    localparam int DIGIT_W      = 4;
    localparam int DEF_MIN_WRAP = 59;
    localparam int DEF_SEC_WRAP = 59;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PAUSED = 2'd1,
        S_ADJ    = 2'd2
    } sw_state_t;

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter used for the seconds and minutes fields.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset, clears both digits
//   clr    in   synchronous clear, wins over inc
//   inc    in   advance the count by one on this clock edge
//   tens   out  BCD tens digit
//   ones   out  BCD ones digit
//   carry  out  high during the cycle in which an accepted inc rolls WRAP over to 00
//
// Parameter WRAP (1..99) is the last value held before rolling back to 00.
module bcd_mod_cnt
    import stopwatch_pkg::*;
#(
    parameter int WRAP = DEF_SEC_WRAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry
);

    localparam logic [6:0] WRAP_VAL = 7'(WRAP);

    logic [6:0]         value;
    logic               at_wrap;
    logic [DIGIT_W-1:0] tens_next;
    logic [DIGIT_W-1:0] ones_next;

    // The wrap test uses the full two-digit value so WRAP need not end in 9.
    // Since counting starts at 00 and steps by one, the value never exceeds WRAP.
    always_comb begin
        value     = 7'(tens) * 7'd10 + 7'(ones);
        at_wrap   = (value == WRAP_VAL);
        tens_next = tens;
        ones_next = ones;
        if (at_wrap) begin
            tens_next = '0;
            ones_next = '0;
        end else if (ones == 4'd9) begin
            ones_next = '0;
            tens_next = tens + 4'd1;
        end else begin
            ones_next = ones + 4'd1;
        end
    end

    // Carry is combinational so the next field advances on the same edge as this wrap.
    assign carry = inc & ~clr & at_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            tens <= tens_next;
            ones <= ones_next;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/adjust state machine, MM:SS BCD
// count and per-field blanking for the seven-segment driver.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   one_hz     in   1 Hz square wave, rising edge advances the count in RUN
//   two_hz     in   2 Hz square wave, rising edge advances the selected field in ADJ
//   blink      in   blink phase, used as a level
//   pause      in   debounced pause button, rising edge toggles run/pause
//   adj        in   adjust-mode switch (level)
//   sel        in   adjust field select, 0 = minutes, 1 = seconds
//   clr        in   clear button, holds all digits at zero while high
//   min_tens   out  BCD minutes tens
//   min_ones   out  BCD minutes ones
//   sec_tens   out  BCD seconds tens
//   sec_ones   out  BCD seconds ones
//   blank_min  out  blank the minute digits
//   blank_sec  out  blank the second digits
//   running    out  high while in RUN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_WRAP = DEF_MIN_WRAP,
    parameter int SEC_WRAP = DEF_SEC_WRAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               one_hz,
    input  logic               two_hz,
    input  logic               blink,
    input  logic               pause,
    input  logic               adj,
    input  logic               sel,
    input  logic               clr,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               blank_min,
    output logic               blank_sec,
    output logic               running
);

    logic      one_hz_q;
    logic      two_hz_q;
    logic      pause_q;
    logic      rise_one_hz;
    logic      rise_two_hz;
    logic      rise_pause;
    sw_state_t state;
    sw_state_t state_next;
    logic      resume_run;
    logic      resume_run_next;
    logic      sec_inc;
    logic      min_inc;
    logic      sec_carry;
    logic      min_carry_unused;

    // History registers come out of reset high so an input already high at
    // reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            one_hz_q <= 1'b1;
            two_hz_q <= 1'b1;
            pause_q  <= 1'b1;
        end else begin
            one_hz_q <= one_hz;
            two_hz_q <= two_hz;
            pause_q  <= pause;
        end
    end

    assign rise_one_hz = one_hz & ~one_hz_q;
    assign rise_two_hz = two_hz & ~two_hz_q;
    assign rise_pause  = pause & ~pause_q;

    // State register plus the remembered run/pause choice that ADJ returns to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            resume_run <= 1'b1;
        end else begin
            state      <= state_next;
            resume_run <= resume_run_next;
        end
    end

    // The adj level is used directly rather than the registered state so that
    // the very cycle adj rises already behaves as ADJ. Pause edges only act
    // outside ADJ and are folded into the remembered run/pause choice.
    always_comb begin
        state_next      = state;
        resume_run_next = resume_run;
        if (adj) begin
            state_next = S_ADJ;
        end else begin
            if (rise_pause) begin
                resume_run_next = ~resume_run;
            end
            state_next = resume_run_next ? S_RUN : S_PAUSED;
        end
    end

    assign running = (state == S_RUN);

    // Increment requests. Counting in RUN uses the pre-toggle run flag so a
    // pause edge coinciding with a tick behaves as if the tick came first.
    // In ADJ the fields are independent, so the seconds carry is not used.
    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        if (adj) begin
            sec_inc = sel & rise_two_hz;
            min_inc = ~sel & rise_two_hz;
        end else begin
            sec_inc = resume_run & rise_one_hz;
            min_inc = resume_run & sec_carry;
        end
    end

    bcd_mod_cnt #(
        .WRAP (SEC_WRAP)
    ) u_sec_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (sec_inc),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    // The minutes roll-over has nowhere to go, so its carry is left unused.
    bcd_mod_cnt #(
        .WRAP (MIN_WRAP)
    ) u_min_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (min_inc),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry_unused)
    );

    // Only the field being adjusted blinks; everything is lit otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
        end else begin
            blank_min <= adj & ~sel & ~blink;
            blank_sec <= adj & sel & ~blink;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl. A behavioural model of the MM:SS
// count and run flag pushes expected outputs into a scoreboard queue as each
// stimulus step is driven; each test pops and compares after the clock edge.
module tb_stopwatch_ctrl;

    localparam int MW = 59;
    localparam int SW = 59;

    logic       clk = 1'b0;
    logic       rst;
    logic       one_hz;
    logic       two_hz;
    logic       blink;
    logic       pause;
    logic       adj;
    logic       sel;
    logic       clr;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blank_min;
    logic       blank_sec;
    logic       running;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          m_min;
    int          m_sec;
    bit          m_run;
    logic [18:0] sb[$];
    logic [18:0] exp_v;
    logic [18:0] obs;

    stopwatch_ctrl #(
        .MIN_WRAP (MW),
        .SEC_WRAP (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .one_hz    (one_hz),
        .two_hz    (two_hz),
        .blink     (blink),
        .pause     (pause),
        .adj       (adj),
        .sel       (sel),
        .clr       (clr),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .blank_min (blank_min),
        .blank_sec (blank_sec),
        .running   (running)
    );

    always #5 clk = ~clk;

    assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, blank_min, blank_sec};

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] bcd16(input int mn, input int sc);
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic push_expected();
        sb.push_back({bcd16(m_min, m_sec),
                      1'(!adj && m_run),
                      1'(adj && !sel && !blink),
                      1'(adj && sel && !blink)});
    endtask

    // One stimulus step: raise the requested edges at a falling clock edge,
    // update the model, push the expectation, and return at the next falling
    // edge with the pulsed inputs lowered again.
    task automatic step(input bit o, input bit t, input bit p, input bit a);
        @(negedge clk);
        one_hz = o;
        two_hz = t;
        pause  = p;
        adj    = a;
        if (clr) begin
            m_min = 0;
            m_sec = 0;
        end else if (a) begin
            if (t) begin
                if (sel) m_sec = (m_sec == SW) ? 0 : m_sec + 1;
                else     m_min = (m_min == MW) ? 0 : m_min + 1;
            end
        end else if (o && m_run) begin
            if (m_sec == SW) begin
                m_sec = 0;
                m_min = (m_min == MW) ? 0 : m_min + 1;
            end else begin
                m_sec = m_sec + 1;
            end
        end
        if (p && !a) m_run = !m_run;
        push_expected();
        @(negedge clk);
        one_hz = 1'b0;
        two_hz = 1'b0;
        pause  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        one_hz = 1'b0;
        two_hz = 1'b0;
        pause  = 1'b0;
        adj    = 1'b0;
        sel    = 1'b0;
        clr    = 1'b0;
        blink  = 1'b1;
        m_min  = 0;
        m_sec  = 0;
        m_run  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        one_hz = 1'b1;
        two_hz = 1'b1;
        pause  = 1'b1;
        adj    = 1'b0;
        sel    = 1'b0;
        clr    = 1'b0;
        blink  = 1'b1;
        m_min  = 0;
        m_sec  = 0;
        m_run  = 1'b1;
        #1;
        push_expected();
        exp_v = sb.pop_front();
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        push_expected();
        exp_v = sb.pop_front();
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL release_high_inputs: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
        end
        one_hz = 1'b0;
        two_hz = 1'b0;
        pause  = 1'b0;
    endtask

    task automatic test_count();
        for (int i = 0; i < 61; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL count_edge_%0d: got %h/%b required %h/%b", i + 1, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_wrap();
        blink = 1'b1;
        sel   = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        while (m_min != 59) step(1'b0, 1'b1, 1'b0, 1'b1);
        sel = 1'b1;
        while (m_sec != 58) step(1'b0, 1'b1, 1'b0, 1'b1);
        sb.delete();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL preload_5958: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL wrap_edge_%0d: got %h/%b required %h/%b", i + 1, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            exp_v = sb.pop_front();
            tests_run++;
            if (i >= 5 && obs !== exp_v && i == 10) begin
                tests_failed++;
                $display("[TB] FAIL pause_resume: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.delete();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL paused_hold_%0d: got %h/%b required %h/%b", i, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v && i == 3) begin
                tests_failed++;
                $display("[TB] FAIL simultaneous_final: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_adjust();
        do_reset();
        sel   = 1'b1;
        blink = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        while (m_sec != 58) step(1'b0, 1'b1, 1'b0, 1'b1);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL adj_sec_edge_%0d: got %h/%b required %h/%b", i + 1, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL adj_ignores_one_hz: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
        end
        for (int i = 0; i < 4; i++) begin
            blink = (i == 1);
            sel   = (i != 2);
            step(1'b0, 1'b0, 1'b0, (i != 3));
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL blank_phase_%0d: got %h/%b required %h/%b", i, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
        blink = 1'b1;
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clr    = 1'b1;
            one_hz = (i % 2 == 0);
            m_min  = 0;
            m_sec  = 0;
            push_expected();
            @(negedge clk);
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL clear_cycle_%0d: got %h/%b required %h/%b", i, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
            one_hz = 1'b0;
        end
        clr = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_v = sb.pop_front();
            tests_run++;
            if (obs !== exp_v && i == 1) begin
                tests_failed++;
                $display("[TB] FAIL clear_release: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        blink = 1'b1;
        sel   = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        while (m_min != 12) step(1'b0, 1'b1, 1'b0, 1'b1);
        sel = 1'b1;
        while (m_sec != 34) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        sb.delete();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL paused_1234: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
        end
        @(posedge clk);
        #3;
        rst   = 1'b0;
        m_min = 0;
        m_sec = 0;
        m_run = 1'b1;
        #1;
        push_expected();
        exp_v = sb.pop_front();
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL async_midreset: got %h/%b required %h/%b", obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_simultaneous();
        test_adjust();
        test_clear();
        test_midreset();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
